// File: rtl/cprv_pkg.sv
// Shared cprv64g definitions: opcodes and load funct3 encodings used by the
// ex, mem and wb stages.
package cprv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/cprv_wb_stage_if.sv
// Write-back stage bus: retire handshake from the mem stage plus the
// register-file write port.
interface cprv_wb_stage_if #(
  parameter int DATA_WIDTH = 64
);

  logic                  valid_wb_i;
  logic                  ready_wb_o;
  logic [4:0]            rd_addr_wb_i;
  logic                  rd_en_wb_i;
  logic [6:0]            opcode_wb_i;
  logic [2:0]            funct3_wb_i;
  logic [DATA_WIDTH-1:0] alu_out_wb_i;
  logic [DATA_WIDTH-1:0] mem_data_wb_i;
  logic                  rd_we_rf_o;
  logic                  ready_rf_i;
  logic [4:0]            rd_addr_rf_o;
  logic [DATA_WIDTH-1:0] rd_data_rf_o;

  modport master (
    output valid_wb_i, rd_addr_wb_i, rd_en_wb_i, opcode_wb_i, funct3_wb_i,
    output alu_out_wb_i, mem_data_wb_i, ready_rf_i,
    input  ready_wb_o, rd_we_rf_o, rd_addr_rf_o, rd_data_rf_o
  );

  modport slave (
    input  valid_wb_i, rd_addr_wb_i, rd_en_wb_i, opcode_wb_i, funct3_wb_i,
    input  alu_out_wb_i, mem_data_wb_i, ready_rf_i,
    output ready_wb_o, rd_we_rf_o, rd_addr_rf_o, rd_data_rf_o
  );

endinterface

// File: rtl/cprv_load_align.sv
// Extracts a byte/half/word/double from an aligned dmem doubleword and
// sign- or zero-extends it; also reports natural-alignment violations.
module cprv_load_align
  import cprv_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] value,
  output logic        misalign
);

  logic [63:0] shifted_s;

  assign shifted_s = data >> {off, 3'b000};

  // Size/sign selection; 3'b111 falls through to the doubleword path.
  always_comb begin
    value    = shifted_s;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  value = {{56{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH: begin
        value    = {{48{shifted_s[15]}}, shifted_s[15:0]};
        misalign = off[0];
      end
      F3_LW: begin
        value    = {{32{shifted_s[31]}}, shifted_s[31:0]};
        misalign = (off[1:0] != 2'b00);
      end
      F3_LBU: value = {56'd0, shifted_s[7:0]};
      F3_LHU: begin
        value    = {48'd0, shifted_s[15:0]};
        misalign = off[0];
      end
      F3_LWU: begin
        value    = {32'd0, shifted_s[31:0]};
        misalign = (off[1:0] != 2'b00);
      end
      default: begin
        value    = shifted_s;
        misalign = (off != 3'b000);
      end
    endcase
  end

endmodule

// File: rtl/cprv_wb_stage.sv
// cprv64g write-back stage: retire handshake, load alignment, one-entry
// register-file write buffer and retired-instruction counter.
module cprv_wb_stage
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  cprv_wb_stage_if.slave bus,
  output logic [63:0]   instret_o,
  output logic          misalign_o
);

  logic                  rd_we_r;
  logic [4:0]            rd_addr_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [63:0]           instret_r;
  logic                  misalign_r;

  logic                  ready_s;
  logic                  accept_s;
  logic                  is_load_s;
  logic [63:0]           load_value_s;
  logic                  load_mis_s;
  logic                  mis_s;
  logic                  write_s;
  logic [DATA_WIDTH-1:0] wb_value_s;

  cprv_load_align u_load_align (
    .data     (bus.mem_data_wb_i),
    .off      (bus.alu_out_wb_i[2:0]),
    .funct3   (bus.funct3_wb_i),
    .value    (load_value_s),
    .misalign (load_mis_s)
  );

  // A drain in the same cycle frees the buffer, so accept without a bubble.
  assign ready_s   = ~rst & (~rd_we_r | bus.ready_rf_i);
  assign accept_s  = bus.valid_wb_i & ready_s;
  assign is_load_s = (bus.opcode_wb_i == LOAD);

  // Write-back value and write qualification for the incoming instruction.
  always_comb begin
    wb_value_s = bus.alu_out_wb_i;
    mis_s      = is_load_s & load_mis_s;
    if (is_load_s) begin
      wb_value_s = load_value_s;
    end else begin
      wb_value_s = bus.alu_out_wb_i;
    end
    write_s = bus.rd_en_wb_i & (bus.rd_addr_wb_i != 5'd0) & ~mis_s;
  end

  // Output write buffer, misalign pulse and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_r    <= 1'b0;
      rd_addr_r  <= 5'd0;
      rd_data_r  <= '0;
      instret_r  <= 64'd0;
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= accept_s & mis_s;
      if (accept_s & ~mis_s) begin
        instret_r <= instret_r + 64'd1;
      end
      if (accept_s) begin
        rd_we_r <= write_s;
        if (write_s) begin
          rd_addr_r <= bus.rd_addr_wb_i;
          rd_data_r <= wb_value_s;
        end
      end else if (rd_we_r & bus.ready_rf_i) begin
        rd_we_r <= 1'b0;
      end
    end
  end

  assign bus.ready_wb_o   = ready_s;
  assign bus.rd_we_rf_o   = rd_we_r;
  assign bus.rd_addr_rf_o = rd_addr_r;
  assign bus.rd_data_rf_o = rd_data_r;
  assign instret_o        = instret_r;
  assign misalign_o       = misalign_r;

endmodule

// File: tb/tb_cprv_wb_stage.sv
// Self-checking bench for cprv_wb_stage: scoreboard of expected RF writes
// popped on every drain, plus per-scenario inline checks.
module tb_cprv_wb_stage;
  import cprv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] instret_o;
  logic        misalign_o;

  cprv_wb_stage_if #(.DATA_WIDTH(64)) bus ();

  cprv_wb_stage #(.DATA_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .instret_o  (instret_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [63:0] exp_instret = 64'd0;

  localparam logic [63:0] MEM_PAT = 64'h8877665544332211;

  function automatic logic [63:0] model_load(input logic [63:0] mem, input logic [2:0] off,
                                             input logic [2:0] f3);
    logic [63:0] s;
    s = mem >> (8 * off);
    case (f3)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b100:  return {56'd0, s[7:0]};
      3'b101:  return {48'd0, s[15:0]};
      3'b110:  return {32'd0, s[31:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] off, input logic [2:0] f3);
    case (f3)
      3'b001, 3'b101: return off[0];
      3'b010, 3'b110: return off[1:0] != 2'b00;
      3'b011, 3'b111: return off != 3'b000;
      default:        return 1'b0;
    endcase
  endfunction

  // Scoreboard: every drain of the write buffer must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rd_we_rf_o === 1'b1 && bus.ready_rf_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got x%0d=%h, required no write",
                 bus.rd_addr_rf_o, bus.rd_data_rf_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rd_addr_rf_o !== mon_e.addr || bus.rd_data_rf_o !== mon_e.data) begin
          errors++;
          $display("FAIL rf_write: got x%0d=%h, required x%0d=%h",
                   bus.rd_addr_rf_o, bus.rd_data_rf_o, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic model_accept();
    logic        is_load;
    logic        mis;
    logic [63:0] value;
    is_load = (bus.opcode_wb_i == LOAD);
    mis     = is_load && model_mis(bus.alu_out_wb_i[2:0], bus.funct3_wb_i);
    value   = is_load ? model_load(bus.mem_data_wb_i, bus.alu_out_wb_i[2:0], bus.funct3_wb_i)
                      : bus.alu_out_wb_i;
    if (!mis) exp_instret = exp_instret + 64'd1;
    if (bus.rd_en_wb_i && bus.rd_addr_wb_i != 5'd0 && !mis)
      exp_q.push_back('{addr: bus.rd_addr_wb_i, data: value});
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic rden, input logic [63:0] alu, input logic [63:0] mem);
    bus.valid_wb_i    = 1'b1;
    bus.opcode_wb_i   = op;
    bus.funct3_wb_i   = f3;
    bus.rd_addr_wb_i  = rd;
    bus.rd_en_wb_i    = rden;
    bus.alu_out_wb_i  = alu;
    bus.mem_data_wb_i = mem;
  endtask

  task automatic idle();
    bus.valid_wb_i = 1'b0;
  endtask

  // Waits (bounded) for the handshake; returns 1 time unit after the accepting edge.
  task automatic accept();
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.ready_wb_o === 1'b1) begin
        @(posedge clk);
        model_accept();
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    #1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready_wb_o=%b for 20 cycles, required 1", bus.ready_wb_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.ready_rf_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rd_we_rf_o, bus.rd_addr_rf_o, bus.rd_data_rf_o} !== 70'd0) begin
      errors++;
      $display("FAIL reset_rf_port: got we=%b addr=%0d data=%h, required 0/0/0",
               bus.rd_we_rf_o, bus.rd_addr_rf_o, bus.rd_data_rf_o);
    end
    checks++;
    if (instret_o !== 64'd0 || misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: got instret=%0d misalign=%b, required 0/0", instret_o, misalign_o);
    end
    checks++;
    if (bus.ready_wb_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got ready_wb_o=%b, required 0", bus.ready_wb_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready_wb_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got ready_wb_o=%b, required 1", bus.ready_wb_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_loads();
    logic [2:0]  t_f3[5]  = '{F3_LB, F3_LBU, F3_LH, F3_LWU, F3_LD};
    logic [2:0]  t_off[5] = '{3'd7, 3'd7, 3'd6, 3'd4, 3'd0};
    logic [63:0] t_exp[5] = '{64'hFFFFFFFFFFFFFF88, 64'h0000000000000088,
                              64'hFFFFFFFFFFFF8877, 64'h0000000088776655,
                              64'h8877665544332211};
    for (int i = 0; i < 5; i++) begin
      drive(LOAD, t_f3[i], 5'(10 + i), 1'b1, {61'h200, t_off[i]}, MEM_PAT);
      accept();
      idle();
      @(negedge clk);
      checks++;
      if (bus.rd_we_rf_o !== 1'b1 || bus.rd_addr_rf_o !== 5'(10 + i) || bus.rd_data_rf_o !== t_exp[i]) begin
        errors++;
        $display("FAIL load_%0d: got we=%b x%0d=%h, required we=1 x%0d=%h", i,
                 bus.rd_we_rf_o, bus.rd_addr_rf_o, bus.rd_data_rf_o, 10 + i, t_exp[i]);
      end
      checks++;
      if (instret_o !== exp_instret) begin
        errors++;
        $display("FAIL load_instret_%0d: got %0d, required %0d", i, instret_o, exp_instret);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_misalign();
    logic [63:0] base = exp_instret;
    drive(LOAD, F3_LW, 5'd5, 1'b1, 64'h2002, MEM_PAT);
    accept();
    idle();
    @(negedge clk);
    checks++;
    if (bus.rd_we_rf_o !== 1'b0 || misalign_o !== 1'b1 || instret_o !== base) begin
      errors++;
      $display("FAIL misalign: got we=%b misalign=%b instret=%0d, required 0/1/%0d",
               bus.rd_we_rf_o, misalign_o, instret_o, base);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (misalign_o !== 1'b0 || instret_o !== base) begin
      errors++;
      $display("FAIL misalign_pulse: got misalign=%b instret=%0d, required 0/%0d",
               misalign_o, instret_o, base);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_x0_nowrite();
    logic [63:0] base = exp_instret;
    drive(OP, 3'b000, 5'd0, 1'b1, 64'hDEADBEEF00000001, 64'd0);
    accept();
    idle();
    @(negedge clk);
    checks++;
    if (bus.rd_we_rf_o !== 1'b0 || instret_o !== base + 64'd1) begin
      errors++;
      $display("FAIL x0_write: got we=%b instret=%0d, required 0/%0d", bus.rd_we_rf_o, instret_o, base + 64'd1);
    end
    @(posedge clk);
    #1;
    drive(STORE, 3'b011, 5'd3, 1'b0, 64'h3000, 64'd0);
    accept();
    idle();
    @(negedge clk);
    checks++;
    if (bus.rd_we_rf_o !== 1'b0 || instret_o !== base + 64'd2) begin
      errors++;
      $display("FAIL store_write: got we=%b instret=%0d, required 0/%0d", bus.rd_we_rf_o, instret_o, base + 64'd2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] base = exp_instret;
    for (int i = 1; i <= 4; i++) begin
      drive(OP, 3'b000, 5'(i), 1'b1, 64'h1111_0000 + 64'(i), 64'd0);
      accept();
      checks++;
      if (bus.rd_we_rf_o !== 1'b1 || bus.rd_addr_rf_o !== 5'(i) || bus.rd_data_rf_o !== 64'h1111_0000 + 64'(i)) begin
        errors++;
        $display("FAIL b2b_%0d: got we=%b x%0d=%h, required we=1 x%0d=%h", i,
                 bus.rd_we_rf_o, bus.rd_addr_rf_o, bus.rd_data_rf_o, i, 64'h1111_0000 + 64'(i));
      end
    end
    idle();
    @(negedge clk);
    checks++;
    if (instret_o !== base + 64'd4) begin
      errors++;
      $display("FAIL b2b_instret: got %0d, required %0d", instret_o, base + 64'd4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [63:0] base;
    bus.ready_rf_i = 1'b0;
    drive(OP, 3'b000, 5'd7, 1'b1, 64'h1234, 64'd0);
    accept();
    base = exp_instret;
    drive(OP, 3'b000, 5'd8, 1'b1, 64'h5678, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ready_wb_o !== 1'b0 || bus.rd_we_rf_o !== 1'b1 || bus.rd_addr_rf_o !== 5'd7 ||
          bus.rd_data_rf_o !== 64'h1234 || instret_o !== base) begin
        errors++;
        $display("FAIL stall_%0d: got ready=%b we=%b x%0d=%h instret=%0d, required 0/1/x7=1234/%0d", c,
                 bus.ready_wb_o, bus.rd_we_rf_o, bus.rd_addr_rf_o, bus.rd_data_rf_o, instret_o, base);
      end
      @(posedge clk);
      #1;
    end
    bus.ready_rf_i = 1'b1;
    accept();
    idle();
    checks++;
    if (bus.rd_we_rf_o !== 1'b1 || bus.rd_addr_rf_o !== 5'd8 || bus.rd_data_rf_o !== 64'h5678) begin
      errors++;
      $display("FAIL drain_accept: got we=%b x%0d=%h, required we=1 x8=5678",
               bus.rd_we_rf_o, bus.rd_addr_rf_o, bus.rd_data_rf_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.ready_rf_i = 1'b0;
    drive(OP, 3'b000, 5'd9, 1'b1, 64'h9999, 64'd0);
    accept();
    idle();
    @(negedge clk);
    checks++;
    if (bus.rd_we_rf_o !== 1'b1) begin
      errors++;
      $display("FAIL pending_before_rst: got we=%b, required 1", bus.rd_we_rf_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_instret = 64'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rd_we_rf_o !== 1'b0 || instret_o !== 64'd0 || bus.ready_wb_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got we=%b instret=%0d ready=%b, required 0/0/0",
               bus.rd_we_rf_o, instret_o, bus.ready_wb_o);
    end
    rst = 1'b0;
    bus.ready_rf_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready_wb_o !== 1'b1 || bus.rd_we_rf_o !== 1'b0) begin
      errors++;
      $display("FAIL after_mid_reset: got ready=%b we=%b, required 1/0", bus.ready_wb_o, bus.rd_we_rf_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.ready_rf_i = 1'b1;
    drive(OP, 3'b000, 5'd0, 1'b0, 64'd0, 64'd0);
    idle();
    test_reset();
    test_loads();
    test_misalign();
    test_x0_nowrite();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
